// File: rtl/pulse_rate_meter.sv
// Multi-channel pulse-rate meter: filtered rising edges per channel counted over one shared gate window.
// Edge reaches the counter 2+FILT_CYC+1 cycles after the pin; results registered one cycle after the terminal gate cycle; no backpressure.
module pulse_rate_meter #(
  parameter int N_CH        = 2,
  parameter int GATE_CYCLES = 5_000_000,
  parameter int CNT_W       = 16,
  parameter int SCALE_SHIFT = 8,
  parameter int OUT_W       = 24,
  parameter int FILT_CYC    = 3
) (
  input  logic                  clk_50m,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [N_CH-1:0]       pulse_in,
  output logic [N_CH*OUT_W-1:0] speed,
  output logic                  speed_valid,
  output logic [N_CH-1:0]       overflow
);
  localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int FC_W   = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
  localparam int WIDE_W = ((CNT_W + SCALE_SHIFT > OUT_W) ? CNT_W + SCALE_SHIFT : OUT_W) + 1;

  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [FC_W-1:0]   FILT_LAST = FC_W'(FILT_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [WIDE_W-1:0] OUT_MAX   = {{(WIDE_W - OUT_W){1'b0}}, {OUT_W{1'b1}}};

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]        state;
  logic [GATE_W-1:0] gate;
  logic              counting;
  logic              terminal;

  // Dropping enable on the terminal cycle suppresses the publish.
  assign counting = (state == RUN) && enable;
  assign terminal = counting && (gate == GATE_LAST);

  always_ff @(posedge clk_50m or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      gate        <= '0;
      speed_valid <= 1'b0;
    end else begin
      state       <= enable ? RUN : IDLE;
      speed_valid <= terminal;
      if (!counting || terminal)
        gate <= '0;
      else
        gate <= gate + 1'b1;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic              sync1, sync2, filt, filt_d, sat;
    logic [FC_W-1:0]   fcnt;
    logic [CNT_W-1:0]  raw;
    logic              edge_det;
    logic [CNT_W:0]    sum;
    logic [CNT_W-1:0]  closed;
    logic [WIDE_W-1:0] scaled;
    logic              ovf_raw;
    logic [OUT_W-1:0]  spd_q;
    logic              ovf_q;

    // An edge arriving in the terminal cycle is folded into the closing window here.
    assign edge_det = filt & ~filt_d;
    assign sum      = {1'b0, raw} + (CNT_W + 1)'(edge_det);
    assign ovf_raw  = sat | sum[CNT_W];
    assign closed   = sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
    assign scaled   = WIDE_W'(closed) << SCALE_SHIFT;

    assign speed[i*OUT_W +: OUT_W] = spd_q;
    assign overflow[i]             = ovf_q;

    always_ff @(posedge clk_50m or negedge rst) begin
      if (!rst) begin
        sync1  <= 1'b0;
        sync2  <= 1'b0;
        filt   <= 1'b0;
        filt_d <= 1'b0;
        fcnt   <= '0;
        raw    <= '0;
        sat    <= 1'b0;
        spd_q  <= '0;
        ovf_q  <= 1'b0;
      end else begin
        sync1  <= pulse_in[i];
        sync2  <= sync1;
        filt_d <= filt;

        if (sync2 != filt) begin
          if (fcnt == FILT_LAST) begin
            filt <= sync2;
            fcnt <= '0;
          end else begin
            fcnt <= fcnt + 1'b1;
          end
        end else begin
          fcnt <= '0;
        end

        if (terminal) begin
          spd_q <= (scaled > OUT_MAX) ? {OUT_W{1'b1}} : scaled[OUT_W-1:0];
          ovf_q <= ovf_raw | (scaled > OUT_MAX);
        end

        if (!counting || terminal) begin
          raw <= '0;
          sat <= 1'b0;
        end else if (edge_det) begin
          if (raw == CNT_MAX)
            sat <= 1'b1;
          else
            raw <= raw + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_pulse_rate_meter.sv
// Bench for pulse_rate_meter: run-length pulse model with timestamped accepted edges, windows counted by time.
module tb_pulse_rate_meter;
  localparam int FILT   = 3;
  localparam int GATE_A = 100;
  localparam int GATE_B = 2000;
  localparam int LAT    = 3 + FILT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_a = 1'b0;
  logic        en_b = 1'b0;
  logic [1:0]  pa = '0;
  logic [0:0]  pb = '0;
  logic [47:0] speed_a;
  logic        valid_a;
  logic [1:0]  ovf_a;
  logic [23:0] speed_b;
  logic        valid_b;
  logic [0:0]  ovf_b;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit va, vb;

  typedef struct { int ch; int t; } ev_t;
  ev_t evq[$];
  int  per[3], hi[3], ph[3], run_len[3], run_st[3], drv_rises[3];
  bit  man[3], lvl[3], acc[3], run_val[3];

  pulse_rate_meter #(.N_CH(2), .GATE_CYCLES(GATE_A), .CNT_W(16), .SCALE_SHIFT(8),
                     .OUT_W(24), .FILT_CYC(FILT)) dut (
    .clk_50m(clk), .rst(rst), .enable(en_a), .pulse_in(pa),
    .speed(speed_a), .speed_valid(valid_a), .overflow(ovf_a));

  pulse_rate_meter #(.N_CH(1), .GATE_CYCLES(GATE_B), .CNT_W(8), .SCALE_SHIFT(8),
                     .OUT_W(24), .FILT_CYC(FILT)) dut_sat (
    .clk_50m(clk), .rst(rst), .enable(en_b), .pulse_in(pb),
    .speed(speed_b), .speed_valid(valid_b), .overflow(ovf_b));

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // A level is accepted once the pin holds it FILT cycles; accepted rises are counted LAT edges after the drive.
  task automatic step();
    @(posedge clk); #1;
    va = valid_a;
    vb = valid_b;
    for (int k = 0; k < 3; k++) begin
      bit v;
      if (per[k] != 0) begin
        ph[k] = (ph[k] + 1) % per[k];
        v = (ph[k] < hi[k]);
      end else begin
        v = man[k];
      end
      if (v && !lvl[k]) drv_rises[k]++;
      lvl[k] = v;
      if (v == run_val[k]) run_len[k]++;
      else begin run_val[k] = v; run_len[k] = 1; run_st[k] = cyc; end
      if (run_len[k] == FILT && v != acc[k]) begin
        acc[k] = v;
        if (v) evq.push_back('{k, run_st[k] + LAT});
      end
    end
    pa = {lvl[1], lvl[0]};
    pb = lvl[2];
  endtask

  function automatic int cnt_ev(input int k, input int lo, input int hi_t);
    int n = 0;
    foreach (evq[j]) if (evq[j].ch == k && evq[j].t > lo && evq[j].t <= hi_t) n++;
    return n;
  endfunction

  function automatic logic [23:0] exp_spd(input int n, input int cw);
    longint cap, c, s;
    cap = (longint'(1) << cw) - 1;
    c = (n > cap) ? cap : longint'(n);
    s = c << 8;
    if (s > 64'hFFFFFF) return 24'hFFFFFF;
    return s[23:0];
  endfunction

  function automatic logic exp_ovf(input int n, input int cw);
    longint cap, c;
    cap = (longint'(1) << cw) - 1;
    c = (n > cap) ? cap : longint'(n);
    return (n > cap) || ((c << 8) > 64'hFFFFFF);
  endfunction

  task automatic wait_v(input bit sel_b, input int budget, output int p, output bit ok);
    ok = 1'b0;
    p = -1;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      if (sel_b ? vb : va) begin ok = 1'b1; p = cyc; end
    end
  endtask

  task automatic reinit_model();
    for (int k = 0; k < 3; k++) begin
      per[k] = 0; hi[k] = 0; ph[k] = 0; man[k] = 1'b0; lvl[k] = 1'b0;
      acc[k] = 1'b0; run_val[k] = 1'b0; run_len[k] = 1000; run_st[k] = 0;
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #2;
    total++; if (speed_a !== 48'd0) begin bad++; $display("FAIL reset_speed_a: got %0h want 0", speed_a); end
    total++; if ({valid_a, ovf_a} !== 3'd0) begin bad++; $display("FAIL reset_flags_a: got %b want 000", {valid_a, ovf_a}); end
    total++; if ({speed_b, valid_b, ovf_b} !== 26'd0) begin bad++; $display("FAIL reset_b: got %0h want 0", {speed_b, valid_b, ovf_b}); end
    repeat (3) step();
    rst = 1'b1;
    repeat (3) step();
    total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL idle_valid: got %b want 0", valid_a); end
  endtask

  task automatic test_steady();
    int e, p, exp_p, n0, n1;
    bit ok;
    per[0] = 10; hi[0] = 5; ph[0] = 0;
    per[1] = 25; hi[1] = 12; ph[1] = 0;
    step();
    en_a = 1'b1;
    e = cyc;
    exp_p = e + 1 + GATE_A;
    for (int w = 0; w < 4; w++) begin
      wait_v(1'b0, GATE_A + 5, p, ok);
      total++; if (!ok || p != exp_p) begin bad++; $display("FAIL steady_timing w%0d: got %0d want %0d", w, p, exp_p); end
      n0 = cnt_ev(0, p - GATE_A, p);
      n1 = cnt_ev(1, p - GATE_A, p);
      total++; if (speed_a[23:0] !== exp_spd(n0, 16)) begin bad++; $display("FAIL steady_ch0 w%0d: got %0d want %0d", w, speed_a[23:0], exp_spd(n0, 16)); end
      total++; if (speed_a[47:24] !== exp_spd(n1, 16)) begin bad++; $display("FAIL steady_ch1 w%0d: got %0d want %0d", w, speed_a[47:24], exp_spd(n1, 16)); end
      total++; if (ovf_a !== {exp_ovf(n1, 16), exp_ovf(n0, 16)}) begin bad++; $display("FAIL steady_ovf w%0d: got %b want 00", w, ovf_a); end
      step();
      total++; if (va !== 1'b0) begin bad++; $display("FAIL steady_strobe w%0d: valid high for 2 cycles", w); end
      exp_p += GATE_A;
    end
  endtask

  task automatic test_random();
    int rem0, rem1, last_p, n0, n1, nwin;
    per[0] = 0; per[1] = 0; man[0] = lvl[0]; man[1] = lvl[1];
    rem0 = 0; rem1 = 0; last_p = -1; nwin = 0;
    for (int i = 0; i < 5 * GATE_A + 20; i++) begin
      if (rem0 == 0) begin man[0] = ~man[0]; rem0 = int'($urandom_range(8, 1)); end
      if (rem1 == 0) begin man[1] = ~man[1]; rem1 = int'($urandom_range(12, 1)); end
      rem0--; rem1--;
      step();
      if (va) begin
        nwin++;
        n0 = cnt_ev(0, cyc - GATE_A, cyc);
        n1 = cnt_ev(1, cyc - GATE_A, cyc);
        total++; if (speed_a[23:0] !== exp_spd(n0, 16)) begin bad++; $display("FAIL rand_ch0: got %0d want %0d", speed_a[23:0], exp_spd(n0, 16)); end
        total++; if (speed_a[47:24] !== exp_spd(n1, 16)) begin bad++; $display("FAIL rand_ch1: got %0d want %0d", speed_a[47:24], exp_spd(n1, 16)); end
        if (last_p >= 0) begin
          total++; if (cyc - last_p != GATE_A) begin bad++; $display("FAIL rand_period: got %0d want %0d", cyc - last_p, GATE_A); end
        end
        last_p = cyc;
      end
    end
    total++; if (nwin < 5) begin bad++; $display("FAIL rand_windows: got %0d want >=5", nwin); end
  endtask

  task automatic test_glitch();
    int p, n0;
    bit ok;
    man[0] = 1'b0; man[1] = 1'b0;
    repeat (2) wait_v(1'b0, GATE_A + 5, p, ok);
    repeat (10) step();
    man[0] = 1'b1; step(); man[0] = 1'b0;
    repeat (10) step();
    man[0] = 1'b1; repeat (2) step(); man[0] = 1'b0;
    wait_v(1'b0, GATE_A + 5, p, ok);
    n0 = cnt_ev(0, p - GATE_A, p);
    total++; if (!ok || speed_a[23:0] !== exp_spd(n0, 16)) begin bad++; $display("FAIL glitch_ignored: got %0d want %0d", speed_a[23:0], exp_spd(n0, 16)); end
    repeat (20) step();
    man[0] = 1'b1; repeat (4) step(); man[0] = 1'b0;
    wait_v(1'b0, GATE_A + 5, p, ok);
    n0 = cnt_ev(0, p - GATE_A, p);
    total++; if (!ok || speed_a[23:0] !== exp_spd(n0, 16)) begin bad++; $display("FAIL glitch_pulse4: got %0d want %0d", speed_a[23:0], exp_spd(n0, 16)); end
  endtask

  task automatic test_terminal();
    int p, p2, r0, sum, n0;
    bit ok;
    wait_v(1'b0, GATE_A + 5, p, ok);
    while (cyc < p + GATE_A - LAT - 1) step();
    r0 = drv_rises[0];
    man[0] = 1'b1; step();
    repeat (4) step();
    man[0] = 1'b0;
    wait_v(1'b0, GATE_A + 5, p2, ok);
    total++; if (!ok || p2 != p + GATE_A) begin bad++; $display("FAIL term_timing: got %0d want %0d", p2, p + GATE_A); end
    total++; if (speed_a[23:0] !== 24'd256) begin bad++; $display("FAIL term_edge_closing: got %0d want 256", speed_a[23:0]); end
    sum = speed_a[23:0] >> 8;
    for (int w = 0; w < 2; w++) begin
      repeat (w + 2) begin
        repeat (5) step();
        man[0] = 1'b1; repeat (3 + w) step(); man[0] = 1'b0;
      end
      wait_v(1'b0, GATE_A + 5, p2, ok);
      n0 = cnt_ev(0, p2 - GATE_A, p2);
      total++; if (!ok || speed_a[23:0] !== exp_spd(n0, 16)) begin bad++; $display("FAIL term_win%0d: got %0d want %0d", w + 2, speed_a[23:0], exp_spd(n0, 16)); end
      sum += int'(speed_a[23:0] >> 8);
    end
    total++; if (sum != drv_rises[0] - r0) begin bad++; $display("FAIL term_total: got %0d want %0d", sum, drv_rises[0] - r0); end
  endtask

  task automatic test_disable();
    int p, e, seen, n0;
    logic [47:0] snap;
    bit ok;
    per[0] = 10; hi[0] = 5; ph[0] = 0;
    wait_v(1'b0, GATE_A + 5, p, ok);
    while (cyc < p + 50) step();
    en_a = 1'b0;
    snap = speed_a;
    seen = 0;
    repeat (20) begin step(); if (va) seen++; end
    total++; if (seen != 0) begin bad++; $display("FAIL dis_no_valid: got %0d strobes want 0", seen); end
    total++; if (speed_a !== snap) begin bad++; $display("FAIL dis_hold: got %0h want %0h", speed_a, snap); end
    en_a = 1'b1;
    e = cyc;
    wait_v(1'b0, GATE_A + 10, p, ok);
    total++; if (!ok || p != e + 1 + GATE_A) begin bad++; $display("FAIL reen_timing: got %0d want %0d", p, e + 1 + GATE_A); end
    n0 = cnt_ev(0, p - GATE_A, p);
    total++; if (speed_a[23:0] !== exp_spd(n0, 16)) begin bad++; $display("FAIL reen_ch0: got %0d want %0d", speed_a[23:0], exp_spd(n0, 16)); end
    while (cyc < p + GATE_A - 1) step();
    en_a = 1'b0;
    snap = speed_a;
    seen = 0;
    repeat (10) begin step(); if (va) seen++; end
    total++; if (seen != 0 || speed_a !== snap) begin bad++; $display("FAIL term_disable: got %0d strobes want 0", seen); end
  endtask

  task automatic test_reset_mid();
    int p, e, n0, n1;
    bit ok;
    per[1] = 25; hi[1] = 12; ph[1] = 0;
    en_a = 1'b1;
    wait_v(1'b0, 2 * GATE_A + 5, p, ok);
    repeat (40) step();
    #3 rst = 1'b0;
    #1;
    total++; if ({speed_a, valid_a, ovf_a} !== 51'd0) begin bad++; $display("FAIL rst_async_a: got %0h want 0", {speed_a, valid_a, ovf_a}); end
    en_a = 1'b0;
    reinit_model();
    repeat (8) step();
    rst = 1'b1;
    step();
    per[0] = 10; hi[0] = 5; per[1] = 25; hi[1] = 12;
    en_a = 1'b1;
    e = cyc;
    wait_v(1'b0, GATE_A + 10, p, ok);
    total++; if (!ok || p != e + 1 + GATE_A) begin bad++; $display("FAIL rst_first_valid: got %0d want %0d", p, e + 1 + GATE_A); end
    n0 = cnt_ev(0, p - GATE_A, p);
    n1 = cnt_ev(1, p - GATE_A, p);
    total++; if (speed_a !== {exp_spd(n1, 16), exp_spd(n0, 16)}) begin bad++; $display("FAIL rst_counts: got %0h want %0h", speed_a, {exp_spd(n1, 16), exp_spd(n0, 16)}); end
    en_a = 1'b0;
    per[0] = 0; per[1] = 0; man[0] = 1'b0; man[1] = 1'b0;
  endtask

  task automatic test_sat();
    int p, n;
    bit ok;
    per[2] = 6; hi[2] = 3; ph[2] = 0;
    en_b = 1'b1;
    wait_v(1'b1, GATE_B + 20, p, ok);
    n = cnt_ev(2, p - GATE_B, p);
    total++; if (!ok || speed_b !== exp_spd(n, 8) || ovf_b[0] !== exp_ovf(n, 8)) begin bad++; $display("FAIL sat_model: got %0d/%b want %0d/%b", speed_b, ovf_b, exp_spd(n, 8), exp_ovf(n, 8)); end
    total++; if (speed_b !== 24'd65280 || ovf_b !== 1'b1) begin bad++; $display("FAIL sat_value: got %0d/%b want 65280/1", speed_b, ovf_b); end
    per[2] = 200; hi[2] = 100;
    wait_v(1'b1, GATE_B + 20, p, ok);
    n = cnt_ev(2, p - GATE_B, p);
    total++; if (!ok || speed_b !== exp_spd(n, 8) || ovf_b[0] !== exp_ovf(n, 8)) begin bad++; $display("FAIL sat_recover_model: got %0d/%b want %0d/%b", speed_b, ovf_b, exp_spd(n, 8), exp_ovf(n, 8)); end
    wait_v(1'b1, GATE_B + 20, p, ok);
    total++; if (!ok || speed_b !== 24'd2560 || ovf_b !== 1'b0) begin bad++; $display("FAIL sat_clear: got %0d/%b want 2560/0", speed_b, ovf_b); end
    en_b = 1'b0;
  endtask

  initial begin
    reinit_model();
    for (int k = 0; k < 3; k++) drv_rises[k] = 0;
    test_reset();
    test_steady();
    test_random();
    test_glitch();
    test_terminal();
    test_disable();
    test_reset_mid();
    test_sat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
